alu_ctrl_mdu: RTL and testbench

ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

---
 rtl/alu_ctrl_mdu.sv | 200 ++++++++++++++++++++
 tb/tb_alu_ctrl_mdu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_mdu.sv
// ALU control decode plus an iterative multiply/divide unit with HI/LO registers.
// One DATA_W-cycle shift-add / restoring-divide pass on magnitudes, then one sign-fix cycle.
module alu_ctrl_mdu #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [3:0]        ID_EX_ALUOp,
    input  logic [25:0]       ID_EX_instr26,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic [4:0]        alu_ctrl_out,
    output logic              stall_req,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hilo_rdata
);

    localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU  = 5'd3,
        OP_SLT  = 5'd4,  OP_SLTU = 5'd5,  OP_MULT = 5'd6,  OP_MULTU = 5'd7,
        OP_DIV  = 5'd8,  OP_DIVU = 5'd9,  OP_AND  = 5'd10, OP_OR    = 5'd11,
        OP_NOR  = 5'd12, OP_XOR  = 5'd13, OP_LUI  = 5'd14, OP_SLL   = 5'd15,
        OP_SRL  = 5'd16, OP_SRA  = 5'd17
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    logic [5:0] funct;
    logic       rtype;
    alu_op_t    alu_op;

    assign funct = ID_EX_instr26[5:0];
    assign rtype = (ID_EX_ALUOp == 4'd0);

    always_comb begin
        alu_op = OP_ADD;
        if (rtype) begin
            case (funct)
                F_ADD:          alu_op = OP_ADD;
                F_ADDU:         alu_op = OP_ADDU;
                F_SUB:          alu_op = OP_SUB;
                F_SUBU:         alu_op = OP_SUBU;
                F_SLT:          alu_op = OP_SLT;
                F_SLTU:         alu_op = OP_SLTU;
                F_MULT:         alu_op = OP_MULT;
                F_MULTU:        alu_op = OP_MULTU;
                F_DIV:          alu_op = OP_DIV;
                F_DIVU:         alu_op = OP_DIVU;
                F_AND:          alu_op = OP_AND;
                F_OR:           alu_op = OP_OR;
                F_NOR:          alu_op = OP_NOR;
                F_XOR:          alu_op = OP_XOR;
                F_SLL, F_SLLV:  alu_op = OP_SLL;
                F_SRL, F_SRLV:  alu_op = OP_SRL;
                F_SRA, F_SRAV:  alu_op = OP_SRA;
                default:        alu_op = OP_ADD;
            endcase
        end else begin
            case (ID_EX_ALUOp)
                4'd1:    alu_op = OP_ADD;
                4'd2:    alu_op = OP_ADDU;
                4'd3:    alu_op = OP_SUB;
                4'd4:    alu_op = OP_SUBU;
                4'd5:    alu_op = OP_SLT;
                4'd6:    alu_op = OP_SLTU;
                4'd7:    alu_op = OP_AND;
                4'd8:    alu_op = OP_OR;
                4'd9:    alu_op = OP_NOR;
                4'd10:   alu_op = OP_XOR;
                4'd11:   alu_op = OP_LUI;
                default: alu_op = OP_ADD;
            endcase
        end
    end

    assign alu_ctrl_out = alu_op;

    logic mdu_arith, mdu_class, op_signed, op_is_div, accept;

    assign mdu_arith = rtype && (funct == F_MULT || funct == F_MULTU ||
                                 funct == F_DIV  || funct == F_DIVU);
    assign mdu_class = mdu_arith || (rtype && (funct == F_MFHI || funct == F_MTHI ||
                                               funct == F_MFLO || funct == F_MTLO));
    assign op_signed = (funct == F_MULT) || (funct == F_DIV);
    assign op_is_div = (funct == F_DIV) || (funct == F_DIVU);

    state_t              state;
    logic [CW-1:0]       count;
    logic [DATA_W-1:0]   acc_hi, acc_lo, opnd;
    logic                is_div, neg_a, neg_b, div_zero;

    assign mdu_busy   = (state != IDLE);
    assign stall_req  = in_valid && mdu_class && mdu_busy;
    assign accept     = (state == IDLE) && in_valid && mdu_arith && !flush;
    assign hilo_rdata = (rtype && funct == F_MFHI) ? hi :
                        (rtype && funct == F_MFLO) ? lo : '0;

    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic                div_borrow, sign_q;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   q_fix, r_fix;

    always_comb begin
        a_mag      = (op_signed && op_a[DATA_W-1]) ? -op_a : op_a;
        b_mag      = (op_signed && op_b[DATA_W-1]) ? -op_b : op_b;
        // acc_lo holds the multiplier (mult) or the dividend bits still to shift in (div)
        mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift  = {acc_hi, acc_lo[DATA_W-1]};
        div_diff   = div_shift - {1'b0, opnd};
        div_borrow = div_shift < {1'b0, opnd};
        sign_q     = neg_a ^ neg_b;
        prod       = {acc_hi, acc_lo};
        prod_fix   = sign_q ? -prod : prod;
        q_fix      = div_zero ? '1 : (sign_q ? -acc_lo : acc_lo);
        r_fix      = neg_a ? -acc_hi : acc_hi;
    end

    logic unused_bits;
    assign unused_bits = ^{ID_EX_instr26[25:6], div_diff[DATA_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            mdu_done <= 1'b0;
        end else begin
            mdu_done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        state    <= CALC;
                        count    <= '0;
                        is_div   <= op_is_div;
                        neg_a    <= op_signed && op_a[DATA_W-1];
                        neg_b    <= op_signed && op_b[DATA_W-1];
                        div_zero <= op_is_div && (op_b == '0);
                        acc_hi   <= '0;
                        acc_lo   <= op_is_div ? a_mag : b_mag;
                        opnd     <= op_is_div ? b_mag : a_mag;
                    end
                    CALC: begin
                        if (is_div) begin
                            acc_hi <= div_borrow ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
                            acc_lo <= {acc_lo[DATA_W-2:0], !div_borrow};
                        end else begin
                            acc_hi <= mul_sum[DATA_W:1];
                            acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                        end
                        if (count == LAST) begin
                            state <= FIX;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    FIX: begin
                        hi       <= is_div ? r_fix : prod_fix[2*DATA_W-1:DATA_W];
                        lo       <= is_div ? q_fix : prod_fix[DATA_W-1:0];
                        mdu_done <= 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
            // MTHI/MTLO stall while busy, so they never collide with the FIX writeback
            if (in_valid && !stall_req && rtype && funct == F_MTHI) hi <= op_a;
            if (in_valid && !stall_req && rtype && funct == F_MTLO) lo <= op_a;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench: cycle-level behavioural model of the MDU timing and results,
// directed literal checks, then randomized traffic compared every cycle.
module tb_alu_ctrl_mdu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [3:0]    aluop = '0;
    logic [25:0]   instr = '0;
    logic [W-1:0]  op_a = '0, op_b = '0;
    logic          flush = 1'b0;
    logic [4:0]    alu_ctrl_out;
    logic          stall_req, mdu_busy, mdu_done;
    logic [W-1:0]  hi, lo, hilo_rdata;

    alu_ctrl_mdu #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ID_EX_ALUOp(aluop),
        .ID_EX_instr26(instr), .op_a(op_a), .op_b(op_b), .flush(flush),
        .alu_ctrl_out(alu_ctrl_out), .stall_req(stall_req), .mdu_busy(mdu_busy),
        .mdu_done(mdu_done), .hi(hi), .lo(lo), .hilo_rdata(hilo_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] exp_alu(input logic [3:0] op, input logic [5:0] f);
        if (op == 4'd0) begin
            case (f)
                6'h20: return 5'd0;   6'h21: return 5'd1;   6'h22: return 5'd2;
                6'h23: return 5'd3;   6'h2A: return 5'd4;   6'h2B: return 5'd5;
                6'h18: return 5'd6;   6'h19: return 5'd7;   6'h1A: return 5'd8;
                6'h1B: return 5'd9;   6'h24: return 5'd10;  6'h25: return 5'd11;
                6'h27: return 5'd12;  6'h26: return 5'd13;
                6'h00, 6'h04: return 5'd15;
                6'h02, 6'h06: return 5'd16;
                6'h03, 6'h07: return 5'd17;
                default: return 5'd0;
            endcase
        end
        case (op)
            4'd1: return 5'd0;   4'd2: return 5'd1;   4'd3: return 5'd2;
            4'd4: return 5'd3;   4'd5: return 5'd4;   4'd6: return 5'd5;
            4'd7: return 5'd10;  4'd8: return 5'd11;  4'd9: return 5'd12;
            4'd10: return 5'd13; 4'd11: return 5'd14;
            default: return 5'd0;
        endcase
    endfunction

    function automatic bit is_arith(input logic [3:0] op, input logic [5:0] f);
        return op == 4'd0 && f >= 6'h18 && f <= 6'h1B;
    endfunction

    function automatic bit is_mdu(input logic [3:0] op, input logic [5:0] f);
        return is_arith(op, f) || (op == 4'd0 && f >= 6'h10 && f <= 6'h13);
    endfunction

    task automatic model_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] h, output logic [W-1:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = '0;
        l = '0;
        case (f)
            6'h18: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            6'h19: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            6'h1A: begin
                if (b == 0) begin h = a; l = '1; end
                else begin q = sa / sb; r = sa % sb; l = 32'(q); h = 32'(r); end
            end
            default: begin
                if (b == 0) begin h = a; l = '1; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endtask

    // Behavioural model: m_left = cycles of busy remaining
    int           m_left = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         m_done = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
        end else begin
            bit st, nd, mt;
            st = in_valid && is_mdu(aluop, instr[5:0]) && m_left > 0;
            mt = in_valid && aluop == 4'd0 && !st;
            nd = 1'b0;
            if (flush) m_left = 0;
            else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; nd = 1'b1; end
            end else if (in_valid && is_arith(aluop, instr[5:0])) begin
                m_left = W + 1;
                model_op(instr[5:0], op_a, op_b, p_hi, p_lo);
            end
            if (mt && instr[5:0] == 6'h11) m_hi = op_a;
            if (mt && instr[5:0] == 6'h13) m_lo = op_a;
            m_done = nd;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            logic [W-1:0] erd;
            erd = (aluop == 0 && instr[5:0] == 6'h10) ? m_hi :
                  (aluop == 0 && instr[5:0] == 6'h12) ? m_lo : '0;
            chk("m_alu", alu_ctrl_out, exp_alu(aluop, instr[5:0]));
            chk("m_busy", mdu_busy, m_left > 0);
            chk("m_stall", stall_req, in_valid && is_mdu(aluop, instr[5:0]) && m_left > 0);
            chk("m_done", mdu_done, m_done);
            chk("m_hi", hi, m_hi);
            chk("m_lo", lo, m_lo);
            chk("m_hilo_rdata", hilo_rdata, erd);
        end
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic fl);
        in_valid = v; aluop = op; instr = {20'h0, f}; op_a = a; op_b = b; flush = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_result(input string name, input logic [W-1:0] eh, input logic [W-1:0] el);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!mdu_busy) break;
            cnt++;
        end
        chk({name, "_busy_cycles"}, cnt, W + 1);
        chk({name, "_done"}, mdu_done, 1'b1);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        drive(1, 0, f, a, b, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        wait_result(name, eh, el);
    endtask

    function automatic logic [W-1:0] rnd_val;
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] h0, l0;
        logic [5:0] flist [12];
        int cnt, pulses;
        flist = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13,
                  6'h20, 6'h2A, 6'h06, 6'h3F};

        #3;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", mdu_busy, 0);
        chk("reset_done", mdu_done, 0);
        drive(0, 0, 6'h2A, 0, 0, 0); #1 chk("dec_slt", alu_ctrl_out, 5'h04);
        drive(0, 0, 6'h06, 0, 0, 0); #1 chk("dec_srlv", alu_ctrl_out, 5'h10);
        drive(0, 0, 6'h3F, 0, 0, 0); #1 chk("dec_unlisted", alu_ctrl_out, 5'h00);
        drive(0, 11, 6'h00, 0, 0, 0); #1 chk("dec_lui", alu_ctrl_out, 5'h0E);
        drive(0, 15, 6'h00, 0, 0, 0); #1 chk("dec_aluop15", alu_ctrl_out, 5'h00);

        // MULT waiting during reset is accepted on the first edge after release
        drive(1, 0, 6'h18, 32'hFFFF_FFFD, 32'd5, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick;
        drive(0, 0, 0, 0, 0, 0);
        wait_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        run_op("divu_zero", 6'h1B, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_op("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("multu", 6'h19, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);

        // DIV then ADD (not stalled) then MFLO held until release
        drive(1, 0, 6'h1A, 32'd100, 32'd7, 0);
        tick;
        drive(1, 0, 6'h20, 32'd1, 32'd2, 0);
        @(negedge clk);
        chk("add_during_calc_stall", stall_req, 0);
        tick;
        drive(1, 0, 6'h12, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_req) break;
            cnt++;
        end
        chk("mflo_stall_cycles", cnt, W);
        chk("mflo_release_done", mdu_done, 1);
        chk("mflo_rdata", hilo_rdata, 32'd14);
        tick;
        drive(0, 0, 0, 0, 0, 0);

        // Flush on the 10th CALC cycle
        h0 = hi; l0 = lo;
        drive(1, 0, 6'h18, 32'd123, 32'd456, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        repeat (9) tick;
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("flush_busy_before", mdu_busy, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("flush_busy_after", mdu_busy, 0);
        chk("flush_hi", hi, h0);
        chk("flush_lo", lo, l0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdu_done) pulses++;
        end
        chk("flush_no_done", pulses, 0);

        // Reset mid-CALC, then MTHI
        drive(1, 0, 6'h19, 32'd9, 32'd9, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) tick;
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_busy", mdu_busy, 0);
        #1 rst_n = 1'b1;
        drive(1, 0, 6'h11, 32'h1234, 0, 0);
        tick;
        chk("mthi_after_rst", hi, 32'h1234);
        drive(0, 0, 0, 0, 0, 0);
        tick;

        for (int i = 0; i < 1500; i++) begin
            logic [3:0] op;
            logic [5:0] f;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : flist[$urandom_range(0, 11)];
            drive($urandom_range(0, 3) != 0, op, f, rnd_val(), rnd_val(),
                  $urandom_range(0, 60) == 0);
            tick;
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (40) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
